// File: rtl/cdb_wakeup_rs.sv
// -----------------------------------------------------------------------------
// cdb_wakeup_rs
//   Reservation station that sits on the consumer side of the CDB. It takes one
//   renamed instruction per cycle from dispatch, snoops SUPERSCALAR_WAY tag
//   broadcasts per cycle to wake waiting source operands, and issues the oldest
//   fully-ready entry into a registered issue stage.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   dispatch_*_i         one instruction write request (op, dest, two sources
//                        with their already-available flags)
//   CDB_en_i / CDB_i     per-way broadcast valid / tag (way w in CDB_i[w*TW +: TW])
//   issue_stall_i        functional unit cannot take the issue register
//   issue_*_o            registered issue stage contents
//   full_o / free_cnt_o  registered occupancy status
//
// Issue handshake: issue_valid_o marks the issue register as holding an
// instruction. The register is transferred to the functional unit on any edge
// where issue_valid_o=1 and issue_stall_i=0. While issue_valid_o=1 and
// issue_stall_i=1 the register contents stay frozen. issue_stall_i is ignored
// while issue_valid_o=0.
// -----------------------------------------------------------------------------
module cdb_wakeup_rs #(
    parameter  int RS_SIZE         = 4,
    parameter  int SUPERSCALAR_WAY = 2,
    parameter  int PHY_REG_NUM     = 8,
    parameter  int OP_W            = 4,
    localparam int TW              = $clog2(PHY_REG_NUM),
    localparam int CW              = $clog2(RS_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dispatch_en_i,
    input  logic [OP_W-1:0]               dispatch_op_i,
    input  logic [TW-1:0]                 dispatch_dest_i,
    input  logic [TW-1:0]                 dispatch_src1_i,
    input  logic                          dispatch_src1_rdy_i,
    input  logic [TW-1:0]                 dispatch_src2_i,
    input  logic                          dispatch_src2_rdy_i,
    input  logic [SUPERSCALAR_WAY-1:0]    CDB_en_i,
    input  logic [SUPERSCALAR_WAY*TW-1:0] CDB_i,
    input  logic                          issue_stall_i,
    output logic                          issue_valid_o,
    output logic [OP_W-1:0]               issue_op_o,
    output logic [TW-1:0]                 issue_dest_o,
    output logic [TW-1:0]                 issue_src1_o,
    output logic [TW-1:0]                 issue_src2_o,
    output logic                          full_o,
    output logic [CW-1:0]                 free_cnt_o
);

    localparam int RW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage
    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [RS_SIZE-1:0] rdy1_q, rdy1_d;
    logic [RS_SIZE-1:0] rdy2_q, rdy2_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [TW-1:0]      dest_q [RS_SIZE];
    logic [TW-1:0]      dest_d [RS_SIZE];
    logic [TW-1:0]      src1_q [RS_SIZE];
    logic [TW-1:0]      src1_d [RS_SIZE];
    logic [TW-1:0]      src2_q [RS_SIZE];
    logic [TW-1:0]      src2_d [RS_SIZE];
    logic [RW-1:0]      rank_q [RS_SIZE];
    logic [RW-1:0]      rank_d [RS_SIZE];

    // Issue register and occupancy
    logic            iss_valid_q, iss_valid_d;
    logic [OP_W-1:0] iss_op_q, iss_op_d;
    logic [TW-1:0]   iss_dest_q, iss_dest_d;
    logic [TW-1:0]   iss_src1_q, iss_src1_d;
    logic [TW-1:0]   iss_src2_q, iss_src2_d;
    logic [CW-1:0]   free_cnt_q, free_cnt_d;
    logic            full_q, full_d;

    // Selection / allocation
    logic          sel_found;
    logic [RW-1:0] sel_idx;
    logic [RW-1:0] sel_rank;
    logic          free_found;
    logic [RW-1:0] free_idx;
    logic          load_ok;
    logic          do_issue;
    logic          do_disp;
    logic [CW-1:0] valid_cnt;

    function automatic logic cdb_hit(
        input logic [TW-1:0]                 tag,
        input logic [SUPERSCALAR_WAY-1:0]    en,
        input logic [SUPERSCALAR_WAY*TW-1:0] bus
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < SUPERSCALAR_WAY; w++) begin
            if (en[w] && (bus[w*TW +: TW] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Oldest ready entry (minimum rank) from registered state only, and the
    // lowest-index free slot for dispatch.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_rank   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
                (!sel_found || (rank_q[i] < sel_rank))) begin
                sel_found = 1'b1;
                sel_idx   = RW'(i);
                sel_rank  = rank_q[i];
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RW'(i);
            end
        end
    end

    always_comb begin
        load_ok   = !iss_valid_q || !issue_stall_i;
        do_issue  = load_ok && sel_found;
        do_disp   = dispatch_en_i && !full_q;
        valid_cnt = CW'(RS_SIZE) - free_cnt_q;

        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            op_d[i]   = op_q[i];
            dest_d[i] = dest_q[i];
            src1_d[i] = src1_q[i];
            src2_d[i] = src2_q[i];
            rank_d[i] = rank_q[i];
        end

        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i]) begin
                if (cdb_hit(src1_q[i], CDB_en_i, CDB_i)) rdy1_d[i] = 1'b1;
                if (cdb_hit(src2_q[i], CDB_en_i, CDB_i)) rdy2_d[i] = 1'b1;
                // Entries younger than the issued one move one step older.
                if (do_issue && (rank_q[i] > sel_rank)) rank_d[i] = rank_q[i] - 1'b1;
            end
            if (do_issue && (RW'(i) == sel_idx)) valid_d[i] = 1'b0;
            // The free slot is never the issuing slot, so no write conflict.
            if (do_disp && (RW'(i) == free_idx)) begin
                valid_d[i] = 1'b1;
                op_d[i]    = dispatch_op_i;
                dest_d[i]  = dispatch_dest_i;
                src1_d[i]  = dispatch_src1_i;
                src2_d[i]  = dispatch_src2_i;
                // Same-cycle broadcast bypass so a tag is never missed.
                rdy1_d[i]  = dispatch_src1_rdy_i || cdb_hit(dispatch_src1_i, CDB_en_i, CDB_i);
                rdy2_d[i]  = dispatch_src2_rdy_i || cdb_hit(dispatch_src2_i, CDB_en_i, CDB_i);
                rank_d[i]  = RW'(valid_cnt - CW'(do_issue));
            end
        end

        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_dest_d  = iss_dest_q;
        iss_src1_d  = iss_src1_q;
        iss_src2_d  = iss_src2_q;
        if (load_ok) begin
            iss_valid_d = sel_found;
            if (sel_found) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (RW'(i) == sel_idx) begin
                        iss_op_d   = op_q[i];
                        iss_dest_d = dest_q[i];
                        iss_src1_d = src1_q[i];
                        iss_src2_d = src2_q[i];
                    end
                end
            end
        end

        free_cnt_d = free_cnt_q + CW'(do_issue) - CW'(do_disp);
        full_d     = (free_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                rank_q[i] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_dest_q  <= '0;
            iss_src1_q  <= '0;
            iss_src2_q  <= '0;
            free_cnt_q  <= CW'(RS_SIZE);
            full_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= op_d[i];
                dest_q[i] <= dest_d[i];
                src1_q[i] <= src1_d[i];
                src2_q[i] <= src2_d[i];
                rank_q[i] <= rank_d[i];
            end
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_dest_q  <= iss_dest_d;
            iss_src1_q  <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;
            free_cnt_q  <= free_cnt_d;
            full_q      <= full_d;
        end
    end

    assign issue_valid_o = iss_valid_q;
    assign issue_op_o    = iss_op_q;
    assign issue_dest_o  = iss_dest_q;
    assign issue_src1_o  = iss_src1_q;
    assign issue_src2_o  = iss_src2_q;
    assign full_o        = full_q;
    assign free_cnt_o    = free_cnt_q;

endmodule

// File: tb/tb_cdb_wakeup_rs.sv
// -----------------------------------------------------------------------------
// tb_cdb_wakeup_rs
//   Directed table-driven bench for cdb_wakeup_rs (RS_SIZE=4, 2 CDB ways,
//   3-bit tags, 4-bit opcodes). Each record is one cycle of inputs plus the
//   hand-computed outputs expected just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_wakeup_rs;

    logic       clk;
    logic       reset;
    logic       dispatch_en_i;
    logic [3:0] dispatch_op_i;
    logic [2:0] dispatch_dest_i;
    logic [2:0] dispatch_src1_i;
    logic       dispatch_src1_rdy_i;
    logic [2:0] dispatch_src2_i;
    logic       dispatch_src2_rdy_i;
    logic [1:0] CDB_en_i;
    logic [5:0] CDB_i;
    logic       issue_stall_i;
    logic       issue_valid_o;
    logic [3:0] issue_op_o;
    logic [2:0] issue_dest_o;
    logic [2:0] issue_src1_o;
    logic [2:0] issue_src2_o;
    logic       full_o;
    logic [2:0] free_cnt_o;

    int errors = 0;
    int checks = 0;

    cdb_wakeup_rs #(
        .RS_SIZE(4), .SUPERSCALAR_WAY(2), .PHY_REG_NUM(8), .OP_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .dispatch_en_i(dispatch_en_i), .dispatch_op_i(dispatch_op_i),
        .dispatch_dest_i(dispatch_dest_i),
        .dispatch_src1_i(dispatch_src1_i), .dispatch_src1_rdy_i(dispatch_src1_rdy_i),
        .dispatch_src2_i(dispatch_src2_i), .dispatch_src2_rdy_i(dispatch_src2_rdy_i),
        .CDB_en_i(CDB_en_i), .CDB_i(CDB_i), .issue_stall_i(issue_stall_i),
        .issue_valid_o(issue_valid_o), .issue_op_o(issue_op_o),
        .issue_dest_o(issue_dest_o), .issue_src1_o(issue_src1_o),
        .issue_src2_o(issue_src2_o), .full_o(full_o), .free_cnt_o(free_cnt_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       disp;
        logic [3:0] op;
        logic [2:0] dest;
        logic [2:0] s1;
        logic       r1;
        logic [2:0] s2;
        logic       r2;
        logic [1:0] cen;
        logic [5:0] cdb;
        logic       stall;
        logic       e_valid;
        logic [2:0] e_dest;
        logic [3:0] e_op;
        logic [2:0] e_free;
        logic       e_full;
    } vec_t;

    function automatic vec_t mk(
        input logic d, input logic [3:0] op, input logic [2:0] dest,
        input logic [2:0] s1, input logic r1, input logic [2:0] s2, input logic r2,
        input logic [1:0] cen, input logic [5:0] cdb, input logic stall,
        input logic ev, input logic [2:0] edest, input logic [3:0] eop,
        input logic [2:0] efree, input logic efull
    );
        vec_t v;
        v.disp = d; v.op = op; v.dest = dest; v.s1 = s1; v.r1 = r1;
        v.s2 = s2; v.r2 = r2; v.cen = cen; v.cdb = cdb; v.stall = stall;
        v.e_valid = ev; v.e_dest = edest; v.e_op = eop;
        v.e_free = efree; v.e_full = efull;
        return v;
    endfunction

    // Idle cycle expecting (valid, dest, op, free, full)
    function automatic vec_t idle(input logic ev, input logic [2:0] edest,
                                  input logic [3:0] eop, input logic [2:0] efree,
                                  input logic efull);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, ev, edest, eop, efree, efull);
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        dispatch_en_i = 0; dispatch_op_i = 0; dispatch_dest_i = 0;
        dispatch_src1_i = 0; dispatch_src1_rdy_i = 0;
        dispatch_src2_i = 0; dispatch_src2_rdy_i = 0;
        CDB_en_i = 0; CDB_i = 0; issue_stall_i = 0;
    endtask

    // Driver: apply one record for a cycle, check just after the edge.
    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        dispatch_en_i = v.disp; dispatch_op_i = v.op; dispatch_dest_i = v.dest;
        dispatch_src1_i = v.s1; dispatch_src1_rdy_i = v.r1;
        dispatch_src2_i = v.s2; dispatch_src2_rdy_i = v.r2;
        CDB_en_i = v.cen; CDB_i = v.cdb; issue_stall_i = v.stall;
        @(posedge clk);
        #1;
        chk({name, ".valid"}, 8'(issue_valid_o), 8'(v.e_valid));
        chk({name, ".free"},  8'(free_cnt_o),    8'(v.e_free));
        chk({name, ".full"},  8'(full_o),        8'(v.e_full));
        if (v.e_valid) begin
            chk({name, ".dest"}, 8'(issue_dest_o), 8'(v.e_dest));
            chk({name, ".op"},   8'(issue_op_o),   8'(v.e_op));
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, ".valid"}, 8'(issue_valid_o), 8'd0);
        chk({name, ".op"},    8'(issue_op_o),    8'd0);
        chk({name, ".dest"},  8'(issue_dest_o),  8'd0);
        chk({name, ".src1"},  8'(issue_src1_o),  8'd0);
        chk({name, ".src2"},  8'(issue_src2_o),  8'd0);
        chk({name, ".full"},  8'(full_o),        8'd0);
        chk({name, ".free"},  8'(free_cnt_o),    8'd4);
    endtask

    vec_t tbl[$];

    initial begin
        // Table: single-instruction latency, CDB wakeup, bypass, oldest-first
        tbl.push_back(mk(1, 3, 5, 1, 1, 2, 1, 2'b00, 6'd0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(idle(1, 5, 3, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));
        tbl.push_back(mk(1, 1, 6, 4, 0, 2, 1, 2'b00, 6'd0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(idle(0, 0, 0, 3, 0));
        tbl.push_back(idle(0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 6'b100_000, 0, 0, 0, 0, 3, 0));
        tbl.push_back(idle(1, 6, 1, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));
        tbl.push_back(mk(1, 2, 3, 6, 0, 0, 1, 2'b01, 6'b000_110, 0, 0, 0, 0, 3, 0));
        tbl.push_back(idle(1, 3, 2, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));
        tbl.push_back(mk(1, 4, 1, 7, 0, 7, 0, 2'b00, 6'd0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 5, 2, 7, 0, 1, 1, 2'b00, 6'd0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 6, 3, 0, 1, 7, 0, 2'b00, 6'd0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 6'b111_111, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle(1, 1, 4, 2, 0));
        // Dispatch D while B issues: D lands in slot 0 but is younger than C.
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 1, 2'b00, 6'd0, 0, 1, 2, 5, 2, 0));
        tbl.push_back(idle(1, 3, 6, 3, 0));
        tbl.push_back(idle(1, 4, 7, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));

        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // Fill with four entries waiting on tag 5, then a dropped fifth.
        for (int k = 0; k < 4; k++)
            apply_vec(mk(1, 4'(8 + k), 3'(k), 5, 0, 5, 0, 2'b00, 6'd0, 0,
                         0, 0, 0, 3'(3 - k), (k == 3)), $sformatf("fill%0d", k));
        apply_vec(mk(1, 15, 7, 1, 1, 1, 1, 2'b00, 6'd0, 0, 0, 0, 0, 0, 1), "drop");
        // Wake all with stall high; empty issue register still loads once.
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 6'b000_101, 1, 0, 0, 0, 0, 1), "wake");
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 1, 1, 0, 8, 1, 0), "stall0");
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 1, 1, 0, 8, 1, 0), "stall1");
        apply_vec(mk(1, 12, 6, 2, 1, 3, 1, 2'b00, 6'd0, 1, 1, 0, 8, 0, 1), "stall_disp");
        apply_vec(idle(1, 1, 9, 1, 0), "drain0");
        apply_vec(idle(1, 2, 10, 2, 0), "drain1");
        apply_vec(idle(1, 3, 11, 3, 0), "drain2");
        apply_vec(idle(1, 6, 12, 4, 0), "drain3");
        apply_vec(idle(0, 0, 0, 4, 0), "drain4");

        // Three entries waiting on tag 6 with a stalled valid issue register.
        apply_vec(mk(1, 1, 1, 0, 1, 0, 1, 2'b00, 6'd0, 0, 0, 0, 0, 3, 0), "pre0");
        apply_vec(mk(1, 2, 2, 6, 0, 6, 0, 2'b00, 6'd0, 0, 1, 1, 1, 3, 0), "pre1");
        apply_vec(mk(1, 3, 3, 6, 0, 6, 0, 2'b00, 6'd0, 1, 1, 1, 1, 2, 0), "pre2");
        apply_vec(mk(1, 4, 4, 6, 0, 6, 0, 2'b00, 6'd0, 1, 1, 1, 1, 1, 0), "pre3");
        #2;
        drive_idle();
        reset = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
        apply_vec(mk(1, 5, 5, 0, 1, 0, 1, 2'b00, 6'd0, 0, 0, 0, 0, 3, 0), "post0");
        // Broadcast tag 6: stale entries must not come back.
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 6'b000_110, 0, 1, 5, 5, 4, 0), "post1");
        apply_vec(idle(0, 0, 0, 4, 0), "post2");
        apply_vec(idle(0, 0, 0, 4, 0), "post3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cdb_wakeup_rs.md
Name: cdb_wakeup_rs

Overview:
Reservation station on the consumer side of the CDB broadcast.
- Accepts one renamed instruction per cycle from dispatch.
- Snoops up to SUPERSCALAR_WAY CDB tag broadcasts per cycle to wake waiting source operands.
- Issues the oldest fully-ready entry through a registered valid/stall output stage to its functional unit.

Parameters:
RS_SIZE, 4, number of entries
SUPERSCALAR_WAY, 2, CDB broadcast ways snooped per cycle
PHY_REG_NUM, 8, physical registers; tag width TW = $clog2(PHY_REG_NUM)
OP_W, 4, opcode width carried through unchanged

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
dispatch_en_i  in  1  dispatch request this cycle
dispatch_op_i  in  OP_W  opcode
dispatch_dest_i  in  TW  destination physical tag
dispatch_src1_i  in  TW  source 1 tag
dispatch_src1_rdy_i  in  1  source 1 already available
dispatch_src2_i  in  TW  source 2 tag
dispatch_src2_rdy_i  in  1  source 2 already available
CDB_en_i  in  SUPERSCALAR_WAY  per-way broadcast valid
CDB_i  in  SUPERSCALAR_WAY*TW  per-way broadcast tag
issue_stall_i  in  1  FU cannot accept the issue register this cycle
issue_valid_o  out  1  issue register holds an instruction
issue_op_o  out  OP_W  issued opcode
issue_dest_o  out  TW  issued destination tag
issue_src1_o  out  TW  issued source 1 tag
issue_src2_o  out  TW  issued source 2 tag
full_o  out  1  all RS_SIZE entries valid
free_cnt_o  out  $clog2(RS_SIZE+1)  number of invalid entries

Behaviour:
- Reset (reset=0, asynchronous):
  - All entry valid bits, ready bits and ranks clear.
  - issue_valid_o=0; issue_op/dest/src1/src2=0; full_o=0; free_cnt_o=RS_SIZE.
  - Reset asserted mid-operation discards all entries and the issue register immediately, with no drain.
- Entry fields: valid, op, dest, src1, rdy1, src2, rdy2, rank.
  - rank = number of valid entries older than this entry; valid ranks are always unique, 0..count-1.
- Wakeup: at each edge, every valid entry with srcN == CDB_i[w] and CDB_en_i[w]=1, for any w, sets rdyN=1.
  - Both ways may match the same entry or carry the same tag; the result is identical to a single match.
- Dispatch: when dispatch_en_i=1 and full_o=0, write the lowest-index invalid entry at the edge.
  - rdyN = dispatch_srcN_rdy_i OR (srcN matches an enabled CDB way in this same cycle). This same-cycle bypass is mandatory.
  - rank = current valid count, minus 1 if an entry is issued at the same edge.
  - dispatch_en_i while full_o=1 is dropped silently, even if an entry issues in that cycle. full_o reflects registered state only.
- Selection (combinational, from registered state only; same-cycle CDB wakeups are not visible): candidates are valid entries with rdy1 & rdy2. Pick the candidate with minimum rank.
- Issue register load condition: issue_valid_o==0 or issue_stall_i==0.
  - If the load condition holds and a candidate exists: copy op/dest/src1/src2 into the issue register, set issue_valid_o=1, invalidate the entry, and decrement every valid entry whose rank exceeds the issued rank.
  - If the load condition holds and no candidate exists: issue_valid_o=0.
  - If the load condition does not hold (valid & stall): hold the register and all entries; wakeup and dispatch continue.
- Latency:
  - Entry dispatched ready at edge k appears on issue_valid_o after edge k+1.
  - Entry woken by CDB in cycle k (edge k) appears after edge k+1.
- free_cnt_o = RS_SIZE − valid count; full_o = (free_cnt_o==0). Both are registered and update at the same edge as entry changes.
- Simultaneous dispatch and issue on the same cycle is legal; the count is unchanged.

Test Plan:
- Reset then dispatch op=3, dest=5, src1=1, src2=2, both rdy=1 at edge 1 -> issue_valid_o=1, issue_dest_o=5 after edge 2; free_cnt_o=4 after edge 2.
- Dispatch src1=4 rdy1=0, src2=2 rdy2=1; two cycles later CDB_en_i=2'b10, CDB_i[1]=4 -> issue_valid_o=1 exactly one edge after the broadcast edge, not before.
- Dispatch src1=6 rdy1=0 in the same cycle as CDB_en_i[0]=1, CDB_i[0]=6 (bypass) -> issued after the next edge, with no further broadcast needed.
- Dispatch A(dest=1), B(dest=2), C(dest=3), all waiting on tag 7; broadcast tag 7; hold issue_stall_i=0 -> issue_dest_o sequence 1, 2, 3 on consecutive cycles.
- Fill 4 non-ready entries -> full_o=1, free_cnt_o=0; a 5th dispatch_en_i is dropped; wake all and hold issue_stall_i=1 -> issue register and its contents are frozen, remaining entries stay valid.
- With 3 entries valid and issue_valid_o=1, pull reset low between edges -> issue_valid_o=0, full_o=0, free_cnt_o=4 immediately; after release, a new dispatch issues normally.
